// File: rtl/linalg_pkg.sv
// Shared helpers for the linear-algebra kernels: width/latency functions and
// the tag record carried alongside each MAC operation.
package linalg_pkg;

  localparam int TAG_ID_W = 4;
  localparam int TAG_C_W  = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int mac_lat(input int in_reg, input int pipe);
    return in_reg + pipe;
  endfunction

  // Generic tag record; widths cover 16 requesters and 32-bit addends/results.
  typedef struct packed {
    logic                       valid;
    logic [TAG_ID_W-1:0]        id;
    logic signed [TAG_C_W-1:0]  c;
  } mac_tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// LAT-deep {valid, id, C} shift register that tracks operations through the
// shared MAC; LAT=0 degenerates to a wire.
module mac_tag_pipe #(
  parameter int LAT  = 2,
  parameter int ID_W = 2,
  parameter int C_W  = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  input  logic [C_W-1:0]  in_c,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic [C_W-1:0]  out_c
);

  generate
    if (LAT == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_id    = in_id;
      assign out_c     = in_c;
    end else begin : g_pipe
      logic              vld_p [LAT];
      logic [ID_W-1:0]   id_p  [LAT];
      logic [C_W-1:0]    c_p   [LAT];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
        end else if (enable) begin
          vld_p[0] <= in_valid;
          for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (enable) begin
          id_p[0] <= in_id;
          c_p[0]  <= in_c;
          for (int i = 1; i < LAT; i++) begin
            id_p[i] <= id_p[i-1];
            c_p[i]  <= c_p[i-1];
          end
        end
      end

      assign out_valid = vld_p[LAT-1];
      assign out_id    = id_p[LAT-1];
      assign out_c     = c_p[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mac_rr_arbiter.sv
// Round-robin front end that shares one MultiplyAdd_NR between NUM_REQ
// requesters and returns each result tagged with its owner.
module mac_rr_arbiter
  import linalg_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int IN_M_WIDTH      = 10,
  parameter int IN_A_WIDTH      = 20,
  parameter int OUT_WIDTH       = 21,
  parameter int INPUT_REG_DEPTH = 1,
  parameter int MULT_PIPE_DEPTH = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*IN_M_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*IN_M_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*IN_A_WIDTH-1:0]  req_c,
  output logic                           mac_reset,
  output logic                           mac_enable,
  output logic                           mac_inReady,
  output logic [IN_M_WIDTH-1:0]          mac_A,
  output logic [IN_M_WIDTH-1:0]          mac_B,
  output logic [IN_A_WIDTH-1:0]          mac_C,
  input  logic                           mac_outReady,
  input  logic [OUT_WIDTH-1:0]           mac_RES,
  output logic                           res_valid,
  output logic [clog2(NUM_REQ)-1:0]      res_id,
  output logic [OUT_WIDTH-1:0]           res_data,
  output logic                           err_sync
);

  localparam int LAT    = mac_lat(INPUT_REG_DEPTH, MULT_PIPE_DEPTH);
  localparam int ID_W   = clog2(NUM_REQ);
  localparam int WARM_W = clog2(LAT + 1);

  logic [ID_W-1:0]               ptr;
  logic                          gnt_hit;
  logic [ID_W-1:0]               gnt_id;
  logic                          transfer;
  logic signed [IN_M_WIDTH-1:0]  a_sel;
  logic signed [IN_M_WIDTH-1:0]  b_sel;
  logic signed [IN_A_WIDTH-1:0]  c_sel;
  logic [WARM_W-1:0]             warm_cnt;
  logic                          warm_done;

  assign mac_reset  = !reset;
  assign mac_enable = enable;

  // Two passes give a wrapping search: first ptr..NUM_REQ-1, then 0..ptr-1.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_hit && req_valid[i] && (ID_W'(i) >= ptr)) begin
        gnt_hit = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_hit && req_valid[i] && (ID_W'(i) < ptr)) begin
        gnt_hit = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
  end

  assign transfer = gnt_hit & enable & reset;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    c_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = transfer && (gnt_id == ID_W'(i));
      if (req_ready[i]) begin
        a_sel = req_a[i*IN_M_WIDTH +: IN_M_WIDTH];
        b_sel = req_b[i*IN_M_WIDTH +: IN_M_WIDTH];
        c_sel = req_c[i*IN_A_WIDTH +: IN_A_WIDTH];
      end
    end
  end

  assign mac_inReady = |(req_valid & req_ready);
  assign mac_A       = a_sel;
  assign mac_B       = b_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // C travels with the tag so it meets the product at the MAC's output adder.
  mac_tag_pipe #(
    .LAT  (LAT),
    .ID_W (ID_W),
    .C_W  (IN_A_WIDTH)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (transfer),
    .in_id     (gnt_id),
    .in_c      (c_sel),
    .out_valid (res_valid),
    .out_id    (res_id),
    .out_c     (mac_C)
  );

  assign res_data = mac_RES;

  // The MAC pipe may hold stale state for its first LAT enabled cycles.
  assign warm_done = (warm_cnt == WARM_W'(LAT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      warm_cnt <= '0;
    end else if (enable && !warm_done) begin
      warm_cnt <= warm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sync <= 1'b0;
    end else if (enable && warm_done && (mac_outReady != res_valid)) begin
      err_sync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Scoreboard bench for mac_rr_arbiter with a behavioural two-stage MAC
// (input register + product register, C added at the output).
module tb_mac_rr_arbiter;
  import linalg_pkg::*;

  localparam int N   = 4;
  localparam int MW  = 10;
  localparam int AW  = 20;
  localparam int OW  = 21;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*MW-1:0] req_a = '0;
  logic [N*MW-1:0] req_b = '0;
  logic [N*AW-1:0] req_c = '0;
  logic            mac_reset, mac_enable, mac_inReady;
  logic [MW-1:0]   mac_A, mac_B;
  logic [AW-1:0]   mac_C;
  logic            mac_outReady;
  logic [OW-1:0]   mac_RES;
  logic            res_valid;
  logic [1:0]      res_id;
  logic [OW-1:0]   res_data;
  logic            err_sync;

  mac_rr_arbiter #(
    .NUM_REQ(N), .IN_M_WIDTH(MW), .IN_A_WIDTH(AW), .OUT_WIDTH(OW),
    .INPUT_REG_DEPTH(1), .MULT_PIPE_DEPTH(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mac_reset(mac_reset), .mac_enable(mac_enable), .mac_inReady(mac_inReady),
    .mac_A(mac_A), .mac_B(mac_B), .mac_C(mac_C),
    .mac_outReady(mac_outReady), .mac_RES(mac_RES),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: RES = C + A*B, product LAT enabled cycles after the inputs.
  logic signed [19:0] mp0, mp1;
  logic               mv0, mv1;
  bit                 force_rdy = 1'b0;

  always @(posedge clk or posedge mac_reset) begin
    if (mac_reset) begin
      mv0 <= 1'b0;
      mv1 <= 1'b0;
    end else if (mac_enable) begin
      mp0 <= signed'(mac_A) * signed'(mac_B);
      mv0 <= mac_inReady;
      mp1 <= mp0;
      mv1 <= mv0;
    end
  end

  assign mac_outReady = mv1 | force_rdy;
  assign mac_RES      = OW'(mp1) + OW'(signed'(mac_C));

  typedef struct {
    mac_tag_t tag;
    int       at;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   ptr = 0;
  int   cyc = 0;
  int   ecyc = 0;
  int   issue_cyc = 0;
  int   last_pop_cyc = -1;

  logic signed [MW-1:0] a_v [N];
  logic signed [MW-1:0] b_v [N];
  logic signed [AW-1:0] c_v [N];

  always @(posedge clk) begin
    cyc++;
    if (reset && enable) ecyc++;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: round-robin over req_valid from ptr; result = C + A*B, LAT enabled cycles later.
  task automatic cycle(input logic [N-1:0] v, input bit en);
    int g, idx;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    #1;
    req_valid = v;
    enable    = en;
    for (int i = 0; i < N; i++) begin
      req_a[i*MW +: MW] = a_v[i];
      req_b[i*MW +: MW] = b_v[i];
      req_c[i*AW +: AW] = c_v[i];
    end
    #1;
    g = -1;
    if (en && reset) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (g < 0 && ((v >> idx) & 1) != 0) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("grant", req_ready, exp_rdy);
    if (g >= 0) begin
      e.tag.valid = 1'b1;
      e.tag.id    = TAG_ID_W'(g);
      e.tag.c     = int'(c_v[g]) + int'(a_v[g]) * int'(b_v[g]);
      e.at        = ecyc + LAT;
      q.push_back(e);
      issue_cyc = cyc;
      ptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b0;
    req_valid = '0;
    #1;
    q.delete();
    ptr = 0;
    check("rst_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err_sync", err_sync, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drain();
    repeat (LAT + 2) cycle('0, 1'b1);
    check("drained", q.size(), 0);
  endtask

  exp_t m;
  always @(negedge clk) begin
    #4;
    if (reset && enable && res_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got id %0d data %0h expected none", res_id, res_data);
      end else begin
        m = q.pop_front();
        check("res_id", res_id, m.tag.id[1:0]);
        check("res_data", res_data, m.tag.c[OW-1:0]);
        check("res_time", ecyc, m.at);
        last_pop_cyc = cyc;
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0; b_v[i] = '0; c_v[i] = '0;
    end
    do_reset();

    // 1: single requester, 100 + 3*-4 = 88
    a_v[2] = 10'sd3; b_v[2] = -10'sd4; c_v[2] = 20'sd100;
    cycle(4'b0100, 1'b1);
    drain();
    check("err_after_t1", err_sync, 0);

    // 2: all valid from ptr 0 -> strict rotation
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_v[i] = MW'(i + 1); b_v[i] = MW'(10 * (i + 1)); c_v[i] = AW'(-1000 * i);
    end
    repeat (8) cycle(4'b1111, 1'b1);
    drain();

    // 3: stall three cycles mid-flight
    a_v[1] = -10'sd7; b_v[1] = 10'sd9; c_v[1] = 20'sd5;
    last_pop_cyc = -1;
    cycle(4'b0010, 1'b1);
    repeat (3) cycle('0, 1'b0);
    drain();
    check("stall_delay", last_pop_cyc - issue_cyc, LAT + 3);

    // 4: reset with two results in flight
    cycle(4'b1111, 1'b1);
    cycle(4'b1111, 1'b1);
    do_reset();
    repeat (LAT + 1) cycle('0, 1'b1);
    cycle(4'b1111, 1'b1);
    drain();

    // 5: only requesters 0 and 3, starting from ptr 3
    do_reset();
    cycle(4'b0100, 1'b1);
    repeat (3) cycle(4'b1001, 1'b1);
    drain();

    // Randomised traffic with stalls
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        a_v[i] = MW'($urandom);
        b_v[i] = MW'($urandom);
        c_v[i] = AW'($urandom);
      end
      cycle(N'($urandom), $urandom_range(0, 4) != 0);
    end
    drain();
    check("err_after_random", err_sync, 0);

    // 6: spurious MAC valid with an empty pipe
    do_reset();
    repeat (4) cycle('0, 1'b1);
    check("err_before_force", err_sync, 0);
    force_rdy = 1'b1;
    cycle('0, 1'b1);
    force_rdy = 1'b0;
    check("err_rise", err_sync, 1);
    repeat (3) cycle('0, 1'b1);
    check("err_sticky", err_sync, 1);
    do_reset();
    check("err_cleared", err_sync, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
